seq_approx_divider: RTL and testbench
=====================================

# seq_approx_divider

Iterative restoring divider: 2·D_W-bit dividend by D_W-bit divisor, giving a D_W-bit quotient and remainder. It computes UNROLL quotient bits per cycle, MSB first. The low APPROX_COLS subtractor columns can use the approximate cell at runtime, selected per operation. It is the sequential, parametrised successor of the combinational array-column dividers and sits behind a valid/ready stream in the accelerator datapath.

## Interface
- D_W, 8: divisor, quotient and remainder width; dividend is 2·D_W.
- APPROX_COLS, 4: number of LSB subtractor columns replaced by the approximate cell when approx_en=1. Range 0..D_W.
- UNROLL, 1: quotient bits resolved per cycle. Legal values are 1, 2 and 4; must divide D_W.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept.
- n  in  2·D_W  dividend.
- d  in  D_W  divisor.
- approx_en  in  1  use approximate low columns for this operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- q  out  D_W  quotient.
- r  out  D_W  remainder.
- div_zero  out  1  d was 0.
- ovf  out  1  n[2·D_W-1:D_W] ≥ d, so the exact quotient does not fit.

## Operation
- **Registers**
  - A: D_W+1 bits, {extra, window}.
  - ND: dividend low bits still to shift in.
  - Latched d, approx_en, step counter, flags.
- **Step** (one quotient bit):
  - Ripple-borrow subtract d from window, column 0 to D_W-1, with bin0=0.
  - Exact cell: diff=x^y^bin; bout=(~x&y)|(~(x^y)&bin).
  - Approximate cell, used in columns j<APPROX_COLS when latched approx_en=1: diff=x&~bin; bout=~bin.
  - Quotient bit: qb = extra | ~bout_last.
  - New remainder: R = qb ? diff : window.
  - If more steps remain: A ← {R, next ND bit}, and qb shifts into the quotient register LSB.
- **Accept:** A ← n[2·D_W-1:D_W-1]; ND ← n[D_W-2:0].
  - div_zero ← (d==0).
  - ovf ← (n[2·D_W-1:D_W] ≥ d), exact compare.
- **Final values:** after D_W steps, r = final R and q = the collected bits.
  - div_zero and ovf do not stop the computation; q and r are whatever the array produces.
- **FSM**
  - IDLE: in_ready=1. On in_valid, latch operands → BUSY with count = D_W/UNROLL.
  - BUSY: UNROLL steps per cycle; count decrements. After the last step → DONE.
  - DONE: out_valid=1; q, r and flags stable. On out_ready → IDLE.
  - in_ready=0 in BUSY and DONE; no accept in the same cycle as a result pop.
- APPROX_COLS=0, or approx_en=0, gives bit-exact restoring division.

## Timing
- **Reset values:** state IDLE; in_ready=1; out_valid=0; q, r, div_zero and ovf = 0.
- Latency from the accept edge to out_valid high is D_W/UNROLL cycles (8 for defaults).
- Throughput is one operation per D_W/UNROLL+2 cycles with out_ready held high.
- Outputs are registered and change only on the transition into DONE.
- in_valid while busy is ignored; the source holds it until in_ready.
- **Reset mid-operation:** abandons the operation and returns to reset values. No partial result is emitted.
- **Operand changes:** n, d or approx_en changing after accept has no effect.

## Structure
- Package seq_approx_divider_pkg holds:
  - state enum (IDLE, BUSY, DONE);
  - helper function computing count width $clog2(D_W/UNROLL+1);
  - parameter legality checks.
- Sub-module div_row holds one step, combinational. Inputs: extra, window, d, approx_en. Parameters: D_W, APPROX_COLS. Outputs: qb, R.
  - The top level instantiates UNROLL rows in a chain.

## Test plan
- **Exact, defaults:** n=1000, d=7, approx_en=0 → after 8 cycles q=142, r=6, div_zero=0, ovf=0.
- **Approximate:** n=0x00FF, d=0x10, approx_en=1, APPROX_COLS=4 → q=0x0A, r=0x0B. Same operands with approx_en=0 → q=0x0F, r=0x0F.
- **Flags:**
  - n=0x0800, d=0x08 → ovf=1.
  - d=0, n=0x1234 → div_zero=1.
  - In both cases out_valid still asserts after 8 cycles.
- **Handshake:**
  - Hold out_ready=0 for 5 cycles in DONE → q/r stable, in_ready=0, and a pending in_valid is not accepted.
  - Release out_ready → IDLE next cycle, new operand accepted the cycle after.
- **Reset:** deassert rst_n 3 cycles into BUSY → outputs zero immediately, in_ready=1 after release, next operation correct.
- **Random:** 2000 vectors with UNROLL∈{1,2,4} and approx_en random → match the bit-accurate step model. Latency is D_W/UNROLL in every case.

Source files
------------

// File: rtl/seq_approx_divider_pkg.sv
// Shared types and elaboration helpers for the sequential approximate divider.
// Holds the FSM state encoding, the step-counter width helper and parameter checks.
package seq_approx_divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  function automatic int count_width(input int d_w, input int unroll);
    return $clog2(d_w / unroll + 1);
  endfunction

  function automatic bit params_legal(input int d_w, input int approx_cols, input int unroll);
    return (d_w >= 2) && (approx_cols >= 0) && (approx_cols <= d_w) &&
           ((unroll == 1) || (unroll == 2) || (unroll == 4)) && ((d_w % unroll) == 0);
  endfunction

endpackage

// File: rtl/seq_approx_divider_row.sv
// One restoring-division step: ripple-borrow subtract of the divisor from the window,
// with the low APPROX_COLS columns optionally swapped for the approximate cell.
module div_row #(
  parameter int D_W         = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic           extra,
  input  logic [D_W-1:0] window,
  input  logic [D_W-1:0] d,
  input  logic           approx_en,
  output logic           qb,
  output logic [D_W-1:0] r
);

  logic [D_W-1:0] diff;
  logic           borrow;

  // The approximate cell ignores the divisor bit and only toggles the borrow chain.
  always_comb begin
    diff   = '0;
    borrow = 1'b0;
    for (int j = 0; j < D_W; j++) begin
      if (approx_en && (j < APPROX_COLS)) begin
        diff[j] = window[j] & ~borrow;
        borrow  = ~borrow;
      end else begin
        diff[j] = window[j] ^ d[j] ^ borrow;
        borrow  = (~window[j] & d[j]) | (~(window[j] ^ d[j]) & borrow);
      end
    end
    qb = extra | ~borrow;
    r  = qb ? diff : window;
  end

endmodule

// File: rtl/seq_approx_divider.sv
// Iterative restoring divider (2*D_W by D_W) resolving UNROLL quotient bits per cycle,
// with a valid/ready handshake on both the operand and result sides.
module seq_approx_divider
  import seq_approx_divider_pkg::*;
#(
  parameter int D_W         = 8,
  parameter int APPROX_COLS = 4,
  parameter int UNROLL      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*D_W-1:0] n,
  input  logic [D_W-1:0]   d,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [D_W-1:0]   q,
  output logic [D_W-1:0]   r,
  output logic             div_zero,
  output logic             ovf
);

  localparam int STEPS = D_W / UNROLL;
  localparam int CW    = count_width(D_W, UNROLL);

  if (!params_legal(D_W, APPROX_COLS, UNROLL)) begin : g_bad_params
    $error("seq_approx_divider: illegal D_W/APPROX_COLS/UNROLL combination");
  end

  state_t         state;
  logic [CW-1:0]  count;
  logic [D_W:0]   a_reg;
  logic [D_W-1:0] nd_reg;
  logic [D_W-1:0] d_reg;
  logic           approx_reg;
  logic [D_W-1:0] q_work;
  logic           dz_pend;
  logic           ovf_pend;
  logic [UNROLL-1:0] qbits;
  logic [D_W-1:0] q_next;

  // Row k feeds row k+1 with its remainder plus the next dividend bit; row 0 is the MSB step.
  for (genvar k = 0; k < UNROLL; k++) begin : g_row
    logic [D_W:0]   a_in;
    logic [D_W:0]   a_nxt;
    logic           qb;
    logic [D_W-1:0] rem;

    if (k == 0) begin : g_first
      assign a_in = a_reg;
    end else begin : g_chain
      assign a_in = g_row[k-1].a_nxt;
    end

    div_row #(
      .D_W        (D_W),
      .APPROX_COLS(APPROX_COLS)
    ) u_row (
      .extra    (a_in[D_W]),
      .window   (a_in[D_W-1:0]),
      .d        (d_reg),
      .approx_en(approx_reg),
      .qb       (qb),
      .r        (rem)
    );

    assign a_nxt             = {rem, nd_reg[D_W-1-k]};
    assign qbits[UNROLL-1-k] = qb;
  end

  assign q_next = (q_work << UNROLL) | D_W'(qbits);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      a_reg      <= '0;
      nd_reg     <= '0;
      d_reg      <= '0;
      approx_reg <= 1'b0;
      q_work     <= '0;
      dz_pend    <= 1'b0;
      ovf_pend   <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      q          <= '0;
      r          <= '0;
      div_zero   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg      <= n[2*D_W-1:D_W-1];
            nd_reg     <= {n[D_W-2:0], 1'b0};
            d_reg      <= d;
            approx_reg <= approx_en;
            dz_pend    <= (d == '0);
            ovf_pend   <= (n[2*D_W-1:D_W] >= d);
            q_work     <= '0;
            count      <= CW'(STEPS);
            in_ready   <= 1'b0;
            state      <= BUSY;
          end
        end
        BUSY: begin
          a_reg  <= g_row[UNROLL-1].a_nxt;
          nd_reg <= nd_reg << UNROLL;
          q_work <= q_next;
          count  <= count - CW'(1);
          if (count == CW'(1)) begin
            q         <= q_next;
            r         <= g_row[UNROLL-1].rem;
            div_zero  <= dz_pend;
            ovf       <= ovf_pend;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_approx_divider.sv
// Self-checking bench: three dividers (UNROLL 1, 2, 4) driven from a vector table,
// hand-written handshake/reset sequences and random operands against an arithmetic model.
module tb_seq_approx_divider;

  localparam int D_W         = 8;
  localparam int APPROX_COLS = 4;
  localparam int NU          = 3;
  localparam int LIMIT       = 40;

  typedef struct {
    logic [15:0] n;
    logic [7:0]  d;
    logic        ap;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        dz;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid  [NU];
  logic        in_ready  [NU];
  logic        approx_en [NU];
  logic        out_valid [NU];
  logic        out_ready [NU];
  logic        div_zero  [NU];
  logic        ovf       [NU];
  logic [15:0] n         [NU];
  logic [7:0]  d         [NU];
  logic [7:0]  q         [NU];
  logic [7:0]  r         [NU];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NU; g++) begin : g_dut
    seq_approx_divider #(
      .D_W        (D_W),
      .APPROX_COLS(APPROX_COLS),
      .UNROLL     (1 << g)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid[g]),
      .in_ready (in_ready[g]),
      .n        (n[g]),
      .d        (d[g]),
      .approx_en(approx_en[g]),
      .out_valid(out_valid[g]),
      .out_ready(out_ready[g]),
      .q        (q[g]),
      .r        (r[g]),
      .div_zero (div_zero[g]),
      .ovf      (ovf[g])
    );
  end

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Arithmetic view of the array: the approximate low columns pass even bits, zero odd
  // bits and hand a constant borrow (APPROX_COLS odd) to the exact upper columns.
  function automatic exp_t model(input logic [15:0] nn, input logic [7:0] dd, input bit ap);
    exp_t        e;
    logic [8:0]  a;
    logic [7:0]  win, diff, rr, qq, even_mask;
    bit          bout, qb;
    int          hi, dhi, bin;
    even_mask = '0;
    for (int j = 0; j < APPROX_COLS; j += 2) even_mask[j] = 1'b1;
    a  = nn[15:7];
    qq = '0;
    rr = '0;
    for (int s = 0; s < D_W; s++) begin
      win = a[7:0];
      if (ap) begin
        hi   = int'(win) >> APPROX_COLS;
        dhi  = int'(dd) >> APPROX_COLS;
        bin  = APPROX_COLS % 2;
        diff = 8'((hi - dhi - bin) << APPROX_COLS) | (win & even_mask);
        bout = (hi < dhi + bin);
      end else begin
        diff = win - dd;
        bout = (win < dd);
      end
      qb = a[8] | ~bout;
      rr = qb ? diff : win;
      qq = {qq[6:0], qb};
      if (s < D_W - 1) a = {rr, nn[6-s]};
    end
    e.q   = qq;
    e.r   = rr;
    e.dz  = (dd == 8'h00);
    e.ovf = (nn[15:8] >= dd);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic apply_stimulus(input int u, input logic [15:0] nn, input logic [7:0] dd,
                                input bit ap, input exp_t e);
    int w = 0;
    while (!in_ready[u] && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    check_val("in_ready_before_accept", in_ready[u], 1);
    in_valid[u]  = 1'b1;
    n[u]         = nn;
    d[u]         = dd;
    approx_en[u] = ap;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid[u]  = 1'b0;
    n[u]         = 16'($urandom);
    d[u]         = 8'($urandom);
    approx_en[u] = 1'($urandom);
  endtask

  task automatic check_output(input int u, input int lat);
    int   cyc = 0;
    exp_t e;
    while (!out_valid[u] && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check_val($sformatf("latency_u%0d", u), cyc, lat);
    if (sb.size() == 0) begin
      check_val("scoreboard_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check_val($sformatf("q_u%0d", u), q[u], e.q);
    check_val($sformatf("r_u%0d", u), r[u], e.r);
    check_val($sformatf("div_zero_u%0d", u), div_zero[u], e.dz);
    check_val($sformatf("ovf_u%0d", u), ovf[u], e.ovf);
    out_ready[u] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[u] = 1'b0;
    check_val($sformatf("out_valid_after_pop_u%0d", u), out_valid[u], 0);
  endtask

  function automatic exp_t vec_exp(input vec_t v);
    exp_t e;
    e.q   = v.q;
    e.r   = v.r;
    e.dz  = v.dz;
    e.ovf = v.ovf;
    return e;
  endfunction

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        tbl[7];
    exp_t        e;
    logic [15:0] nn;
    logic [7:0]  dd;
    bit          ap;
    int          u, w;

    tbl[0] = '{16'd1000,  8'd7,   1'b0, 8'd142, 8'd6,   1'b0, 1'b0};
    tbl[1] = '{16'h00FF,  8'h10,  1'b1, 8'h0A,  8'h0B,  1'b0, 1'b0};
    tbl[2] = '{16'h00FF,  8'h10,  1'b0, 8'h0F,  8'h0F,  1'b0, 1'b0};
    tbl[3] = '{16'h0800,  8'h08,  1'b0, 8'hFF,  8'h08,  1'b0, 1'b1};
    tbl[4] = '{16'h1234,  8'h00,  1'b0, 8'hFF,  8'h34,  1'b1, 1'b1};
    tbl[5] = '{16'hFEFF,  8'hFF,  1'b0, 8'hFF,  8'hFE,  1'b0, 1'b0};
    tbl[6] = '{16'h0000,  8'h01,  1'b0, 8'h00,  8'h00,  1'b0, 1'b0};

    for (int i = 0; i < NU; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b0;
      approx_en[i] = 1'b0;
      n[i]         = '0;
      d[i]         = '0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    for (int i = 0; i < NU; i++) begin
      check_val($sformatf("reset_in_ready_u%0d", i), in_ready[i], 1);
      check_val($sformatf("reset_out_valid_u%0d", i), out_valid[i], 0);
    end
    check_val("reset_q", q[0], 0);
    check_val("reset_r", r[0], 0);
    check_val("reset_div_zero", div_zero[0], 0);
    check_val("reset_ovf", ovf[0], 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table on every unroll factor
    for (int k = 0; k < NU; k++) begin
      for (int i = 0; i < 7; i++) begin
        apply_stimulus(k, tbl[i].n, tbl[i].d, tbl[i].ap, vec_exp(tbl[i]));
        check_output(k, D_W >> k);
      end
    end

    // Result held in DONE while out_ready stays low; a waiting operand is not taken
    apply_stimulus(0, 16'd1000, 8'd7, 1'b0, vec_exp(tbl[0]));
    w = 0;
    while (!out_valid[0] && w < LIMIT) begin
      @(negedge clk);
      w++;
    end
    check_val("hold_latency", w, D_W);
    in_valid[0]  = 1'b1;
    n[0]         = 16'h00FF;
    d[0]         = 8'h10;
    approx_en[0] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_val("hold_q", q[0], 142);
      check_val("hold_r", r[0], 6);
      check_val("hold_out_valid", out_valid[0], 1);
      check_val("hold_in_ready", in_ready[0], 0);
    end
    e = sb.pop_front();
    check_val("hold_sb_q", q[0], e.q);
    sb.push_back(vec_exp(tbl[2]));
    out_ready[0] = 1'b1;
    @(negedge clk);
    out_ready[0] = 1'b0;
    check_val("release_out_valid", out_valid[0], 0);
    check_val("release_in_ready", in_ready[0], 1);
    @(negedge clk);
    check_val("release_accepted", in_ready[0], 0);
    in_valid[0] = 1'b0;
    n[0]        = 16'hBEEF;
    d[0]        = 8'h03;
    check_output(0, D_W);

    // Reset three cycles into BUSY
    in_valid[0]  = 1'b1;
    n[0]         = 16'h0ABC;
    d[0]         = 8'h35;
    approx_en[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midreset_out_valid", out_valid[0], 0);
    check_val("midreset_in_ready", in_ready[0], 1);
    check_val("midreset_q", q[0], 0);
    check_val("midreset_r", r[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("postreset_in_ready", in_ready[0], 1);
    check_val("postreset_out_valid", out_valid[0], 0);
    apply_stimulus(0, tbl[0].n, tbl[0].d, tbl[0].ap, vec_exp(tbl[0]));
    check_output(0, D_W);

    // Random operands against the model
    for (int i = 0; i < 2000; i++) begin
      u  = $urandom_range(0, NU - 1);
      nn = 16'($urandom);
      dd = 8'($urandom);
      ap = 1'($urandom);
      if ($urandom_range(0, 1) == 1 && dd != 8'h00) nn[15:8] = nn[15:8] % dd;
      apply_stimulus(u, nn, dd, ap, model(nn, dd, ap));
      check_output(u, D_W >> u);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
